// File: rtl/skew_checker_pkg.sv
// rtl/skew_checker_pkg.sv - shared state type, skew width and skew helpers for event_skew_checker.
package skew_checker_pkg;

    localparam int SKEW_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAIL = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef logic signed [SKEW_W-1:0] skew_t;

    // Simultaneous A and B events cancel, so only a lone strobe moves the skew.
    function automatic skew_t skew_step(input skew_t s, input logic a, input logic b);
        skew_t r;
        case ({a, b})
            2'b10:   r = s + skew_t'(1);
            2'b01:   r = s - skew_t'(1);
            default: r = s;
        endcase
        return r;
    endfunction

    function automatic logic skew_exceeds(input skew_t s, input int max_skew);
        int v;
        v = int'(s);
        return (v > max_skew) || (v < -max_skew);
    endfunction

endpackage

// File: rtl/skew_event_counter.sv
// rtl/skew_event_counter.sv - wrapping event counter with synchronous clear and count enable.
module skew_event_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/event_skew_checker.sv
// rtl/event_skew_checker.sv - checks producer/consumer event skew over a run of NUM_TESTS B events.
// Optional fail_count_b capture port under SKEW_CHECKER_CAPTURE_EN.
module event_skew_checker
    import skew_checker_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_TESTS = 100,
    parameter int MAX_SKEW  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              inc_a,
    input  logic              inc_b,
    output logic [WIDTH-1:0]  count_a,
    output logic [WIDTH-1:0]  count_b,
    output logic [SKEW_W-1:0] skew,
    output logic              busy,
    output logic              done,
    output logic              error
`ifdef SKEW_CHECKER_CAPTURE_EN
    ,
    output logic [WIDTH-1:0]  fail_count_b
`endif
);

    state_e      state_q;
    state_e      state_d;
    skew_t       skew_q;
    skew_t       skew_d;
    logic [15:0] btotal_q;
    logic [15:0] btotal_d;

    logic        run;
    logic        clr;
    logic        en_a;
    logic        en_b;

    assign run  = (state_q == ST_RUN);
    assign clr  = start && !run;
    assign en_a = run && inc_a;
    assign en_b = run && inc_b;

    skew_event_counter #(.WIDTH(WIDTH)) u_cnt_a (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .en_i    (en_a),
        .count_o (count_a)
    );

    skew_event_counter #(.WIDTH(WIDTH)) u_cnt_b (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .en_i    (en_b),
        .count_o (count_b)
    );

    // The B total is kept apart from count_b so run length is immune to its wrap.
    always_comb begin
        state_d  = state_q;
        skew_d   = skew_q;
        btotal_d = btotal_q;
        case (state_q)
            ST_RUN: begin
                skew_d   = skew_step(skew_q, inc_a, inc_b);
                btotal_d = btotal_q + 16'(inc_b);
                if (skew_exceeds(skew_d, MAX_SKEW)) begin
                    state_d = ST_FAIL;
                end else if (btotal_d == 16'(NUM_TESTS)) begin
                    state_d = (skew_d == '0) ? ST_DONE : ST_FAIL;
                end
            end
            default: begin
                if (start) begin
                    skew_d   = '0;
                    btotal_d = '0;
                    state_d  = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            skew_q   <= '0;
            btotal_q <= '0;
        end else begin
            state_q  <= state_d;
            skew_q   <= skew_d;
            btotal_q <= btotal_d;
        end
    end

    assign skew  = skew_q;
    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);
    assign error = (state_q == ST_FAIL);

`ifdef SKEW_CHECKER_CAPTURE_EN
    logic [WIDTH-1:0] fail_count_b_q;
    logic [WIDTH-1:0] count_b_next;
    logic             fail_entry;

    // Capture the count_b value that lands on the same edge as the FAIL transition.
    assign count_b_next = count_b + WIDTH'(inc_b);
    assign fail_entry   = run && (state_d == ST_FAIL);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            fail_count_b_q <= '0;
        end else if (fail_entry) begin
            fail_count_b_q <= count_b_next;
        end
    end

    assign fail_count_b = fail_count_b_q;
`endif

endmodule

// File: tb/tb_event_skew_checker.sv
// tb/tb_event_skew_checker.sv - table plus scoreboard bench for event_skew_checker (default and WIDTH=4/NUM_TESTS=20 instances).
module tb_event_skew_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, start = 1'b0, inc_a = 1'b0, inc_b = 1'b0;

    logic [7:0] ca0, cb0, fcb0;
    logic [3:0] ca1, cb1, fcb1;
    logic [4:0] sk0, sk1;
    logic       busy0, done0, err0, busy1, done1, err1;

    event_skew_checker u0 (
        .clk(clk), .rst(rst), .start(start), .inc_a(inc_a), .inc_b(inc_b),
        .count_a(ca0), .count_b(cb0), .skew(sk0), .busy(busy0), .done(done0), .error(err0)
`ifdef SKEW_CHECKER_CAPTURE_EN
        , .fail_count_b(fcb0)
`endif
    );

    event_skew_checker #(.WIDTH(4), .NUM_TESTS(20), .MAX_SKEW(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .inc_a(inc_a), .inc_b(inc_b),
        .count_a(ca1), .count_b(cb1), .skew(sk1), .busy(busy1), .done(done1), .error(err1)
`ifdef SKEW_CHECKER_CAPTURE_EN
        , .fail_count_b(fcb1)
`endif
    );

`ifndef SKEW_CHECKER_CAPTURE_EN
    assign fcb0 = 8'd0;
    assign fcb1 = 4'd0;
`endif

    typedef struct packed {
        logic [7:0] ca;
        logic [7:0] cb;
        logic [4:0] sk;
        logic       busy;
        logic       done;
        logic       err;
        logic [7:0] fcb;
    } obs_t;

    typedef struct {
        string name;
        obs_t  e0;
        obs_t  e1;
    } sb_t;

    typedef struct {
        logic r, s, a, b;
        obs_t e;
    } vec_t;

    sb_t  sbq[$];
    vec_t tab[15];
    int   passed = 0;
    int   total  = 0;

    // Reference model: 0 IDLE, 1 RUN, 2 FAIL, 3 DONE
    localparam int MAXS = 1;
    int m_st[2], m_ca[2], m_cb[2], m_sk[2], m_bt[2], m_fcb[2];
    int mask[2]  = '{255, 15};
    int ntest[2] = '{100, 20};

    function automatic obs_t model_obs(int i);
        obs_t o;
        o.ca   = 8'(m_ca[i]);
        o.cb   = 8'(m_cb[i]);
        o.sk   = 5'(m_sk[i]);
        o.busy = (m_st[i] == 1);
        o.done = (m_st[i] == 3);
        o.err  = (m_st[i] == 2);
        o.fcb  = 8'(m_fcb[i]);
        return o;
    endfunction

    task automatic model_step(input logic r, input logic s, input logic a, input logic b);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_st[i] = 0; m_ca[i] = 0; m_cb[i] = 0; m_sk[i] = 0; m_bt[i] = 0; m_fcb[i] = 0;
            end else if (m_st[i] == 1) begin
                m_ca[i] = (m_ca[i] + int'(a)) & mask[i];
                m_cb[i] = (m_cb[i] + int'(b)) & mask[i];
                m_sk[i] = m_sk[i] + int'(a) - int'(b);
                m_bt[i] = m_bt[i] + int'(b);
                if (m_sk[i] > MAXS || m_sk[i] < -MAXS) begin
                    m_st[i] = 2; m_fcb[i] = m_cb[i];
                end else if (m_bt[i] == ntest[i]) begin
                    m_st[i] = (m_sk[i] == 0) ? 3 : 2;
                    if (m_st[i] == 2) m_fcb[i] = m_cb[i];
                end
            end else if (s) begin
                m_st[i] = 1; m_ca[i] = 0; m_cb[i] = 0; m_sk[i] = 0; m_bt[i] = 0; m_fcb[i] = 0;
            end
        end
    endtask

    function automatic obs_t act_obs(int i);
        obs_t o;
        if (i == 0) o = '{ca0, cb0, sk0, busy0, done0, err0, fcb0};
        else        o = '{{4'd0, ca1}, {4'd0, cb1}, sk1, busy1, done1, err1, {4'd0, fcb1}};
        return o;
    endfunction

    task automatic cmp_obs(input string nm, input int i, input obs_t act, input obs_t exp);
`ifndef SKEW_CHECKER_CAPTURE_EN
        exp.fcb = 8'd0;
`endif
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s inst%0d act=%h exp=%h", nm, i, act, exp);
    endtask

    task automatic check_out();
        sb_t e;
        if (sbq.size() == 0) begin
            total++;
            $display("FAIL scoreboard_empty act=0 exp=1");
        end else begin
            e = sbq.pop_front();
            cmp_obs(e.name, 0, act_obs(0), e.e0);
            cmp_obs(e.name, 1, act_obs(1), e.e1);
        end
    endtask

    task automatic apply(input string nm, input logic r, input logic s, input logic a,
                         input logic b, input bit use_tab, input obs_t te);
        sb_t e;
        rst = r; start = s; inc_a = a; inc_b = b;
        model_step(r, s, a, b);
        e.name = nm;
        e.e0   = use_tab ? te : model_obs(0);
        e.e1   = use_tab ? te : model_obs(1);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic step(input string nm, input logic r, input logic s, input logic a, input logic b);
        apply(nm, r, s, a, b, 1'b0, '0);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    endtask

    function automatic vec_t mk(logic r, logic s, logic a, logic b, int ca, int cb, int sk,
                                logic bz, logic dn, logic er, int fcb);
        vec_t v;
        v.r = r; v.s = s; v.a = a; v.b = b;
        v.e = '{8'(ca), 8'(cb), 5'(sk), bz, dn, er, 8'(fcb)};
        return v;
    endfunction

    initial begin
        tab[0]  = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        tab[1]  = mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0);
        tab[2]  = mk(0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0);
        tab[3]  = mk(0, 0, 1, 0, 1, 0,  1, 1, 0, 0, 0);
        tab[4]  = mk(0, 0, 0, 1, 1, 1,  0, 1, 0, 0, 0);
        tab[5]  = mk(0, 0, 1, 1, 2, 2,  0, 1, 0, 0, 0);
        tab[6]  = mk(0, 0, 0, 0, 2, 2,  0, 1, 0, 0, 0);
        tab[7]  = mk(0, 0, 0, 1, 2, 3, -1, 1, 0, 0, 0);
        tab[8]  = mk(0, 0, 1, 0, 3, 3,  0, 1, 0, 0, 0);
        tab[9]  = mk(0, 0, 1, 0, 4, 3,  1, 1, 0, 0, 0);
        tab[10] = mk(0, 0, 1, 0, 5, 3,  2, 0, 0, 1, 3);
        tab[11] = mk(0, 0, 1, 1, 5, 3,  2, 0, 0, 1, 3);
        tab[12] = mk(0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0);
        tab[13] = mk(0, 1, 1, 0, 1, 0,  1, 1, 0, 0, 0);
        tab[14] = mk(1, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0);

        for (int i = 0; i < 15; i++) begin
            apply($sformatf("tab%0d", i), tab[i].r, tab[i].s, tab[i].a, tab[i].b, 1'b1, tab[i].e);
        end

        // Lockstep run; the narrow instance wraps 20 -> 4 and finishes early.
        step("ls_rst", 1, 0, 0, 0);
        step("ls_start", 0, 1, 0, 0);
        for (int i = 0; i < 100; i++) step("ls_run", 0, 0, 1, 1);
        chk("ls_done0", int'(done0), 1);
        chk("ls_err0", int'(err0), 0);
        chk("ls_ca0", int'(ca0), 100);
        chk("ls_cb0", int'(cb0), 100);
        chk("ls_skew0", int'(sk0), 0);
        chk("wrap_ca1", int'(ca1), 4);
        chk("wrap_cb1", int'(cb1), 4);
        chk("wrap_done1", int'(done1), 1);
        step("ls_after", 0, 0, 1, 0);

        // A leads B by one event for the whole run.
        step("imb_rst", 1, 0, 0, 0);
        step("imb_start", 0, 1, 0, 0);
        step("imb_lead", 0, 0, 1, 0);
        for (int i = 0; i < 100; i++) step("imb_run", 0, 0, 1, 1);
        chk("imb_err0", int'(err0), 1);
        chk("imb_done0", int'(done0), 0);
        chk("imb_skew0", int'(sk0), 1);

        // Reset in the middle of a run, then a clean run.
        step("mr_rst", 1, 0, 0, 0);
        step("mr_start", 0, 1, 0, 0);
        for (int i = 0; i < 50; i++) step("mr_run", 0, 0, 1, 1);
        step("mr_hit", 1, 1, 1, 1);
        chk("mr_idle", int'({ca0, cb0, sk0, busy0, done0, err0}), 0);
        step("mr_start2", 0, 1, 0, 0);
        for (int i = 0; i < 100; i++) step("mr_run2", 0, 0, 1, 1);
        chk("mr_done0", int'(done0), 1);

        // Over-skew after 7 B events; the capture must survive later strobes.
        step("cap_rst", 1, 0, 0, 0);
        step("cap_start", 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) step("cap_run", 0, 0, 1, 1);
        step("cap_a1", 0, 0, 1, 0);
        step("cap_a2", 0, 0, 1, 0);
        chk("cap_err0", int'(err0), 1);
        chk("cap_skew0", int'(sk0), 2);
        for (int i = 0; i < 3; i++) step("cap_hold", 0, 0, 1, 1);
        chk("cap_cb0", int'(cb0), 7);
`ifdef SKEW_CHECKER_CAPTURE_EN
        chk("cap_fcb0", int'(fcb0), 7);
`endif
        step("cap_restart", 0, 1, 0, 0);
`ifdef SKEW_CHECKER_CAPTURE_EN
        chk("cap_fcb0_clr", int'(fcb0), 0);
`endif
        step("end_idle", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
